// File: rtl/ps2mouse_init_seq_if.sv
// rtl/ps2mouse_init_seq_if.sv - byte handshake between the init sequencer and the PS/2 byte transceiver
interface ps2mouse_init_seq_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;

  modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid, rx_error);
  modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid, rx_error);
endinterface

// File: rtl/ps2mouse_init_seq.sv
// rtl/ps2mouse_init_seq.sv - PS/2 mouse reset/configure sequencer (FF, sample rate 200/100/80, ID, enable)
// Optional hot-plug re-init on AA,00 while running: define PS2MOUSE_INIT_HOTPLUG_EN
module ps2mouse_init_seq #(
  parameter int C_ack_timeout = 250000,
  parameter int C_bat_timeout = 25000000,
  parameter int C_retries     = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_ena,
  ps2mouse_init_seq_if.master bus,
  output logic                stream_en,
  output logic                wheel,
  output logic                init_done,
  output logic                init_fail,
  output logic [1:0]          retry_cnt
);
  localparam int TW = $clog2(((C_bat_timeout > C_ack_timeout) ? C_bat_timeout : C_ack_timeout) + 1);
  localparam logic [TW-1:0] ACK_LAST  = TW'(C_ack_timeout - 1);
  localparam logic [TW-1:0] BAT_LAST  = TW'(C_bat_timeout - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(C_retries);
  localparam logic [3:0]    LAST_STEP = 4'd8;

  typedef enum logic [2:0] {START, SEND, WAIT_RSP, RUN, FAIL} state_t;

  state_t        state, state_n;
  logic [3:0]    step, step_n;
  logic [1:0]    rsp_idx, rsp_idx_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic [1:0]    retry_n;
  logic          wheel_n;
  logic [7:0]    cmd_byte;
  logic [7:0]    exp_byte;
  logic          bat_rsp;
  logic          id_rsp;
  logic          last_rsp;
  logic          tmo_hit;
  logic          rx_ok;
  logic          step_fail;
`ifdef PS2MOUSE_INIT_HOTPLUG_EN
  logic          hp_aa, hp_aa_n;
`endif

  always_comb begin
    cmd_byte = 8'hF4;
    case (step)
      4'd0:    cmd_byte = 8'hFF;
      4'd1:    cmd_byte = 8'hF3;
      4'd2:    cmd_byte = 8'hC8;
      4'd3:    cmd_byte = 8'hF3;
      4'd4:    cmd_byte = 8'h64;
      4'd5:    cmd_byte = 8'hF3;
      4'd6:    cmd_byte = 8'h50;
      4'd7:    cmd_byte = 8'hF2;
      default: cmd_byte = 8'hF4;
    endcase
  end

  // Step 0 expects FA,AA,00; step 7 expects FA,ID; every other step a lone FA.
  assign bat_rsp  = (step == 4'd0) && (rsp_idx != 2'd0);
  assign id_rsp   = (step == 4'd7) && (rsp_idx == 2'd1);
  assign last_rsp = (step == 4'd0) ? (rsp_idx == 2'd2) :
                    (step == 4'd7) ? (rsp_idx == 2'd1) : 1'b1;
  assign exp_byte = !bat_rsp ? 8'hFA : (rsp_idx == 2'd1) ? 8'hAA : 8'h00;
  assign tmo_hit  = (tmo_cnt == (bat_rsp ? BAT_LAST : ACK_LAST));
  // NAK (FE) and error (FC) never equal an expected byte, so they fail as mismatches.
  assign rx_ok    = id_rsp || (bus.rx_data == exp_byte);

  always_comb begin
    state_n   = state;
    step_n    = step;
    rsp_idx_n = rsp_idx;
    tmo_cnt_n = tmo_cnt;
    retry_n   = retry_cnt;
    wheel_n   = wheel;
    step_fail = 1'b0;
`ifdef PS2MOUSE_INIT_HOTPLUG_EN
    hp_aa_n   = hp_aa;
`endif
    case (state)
      START: begin
        state_n = SEND;
        step_n  = 4'd0;
`ifdef PS2MOUSE_INIT_HOTPLUG_EN
        hp_aa_n = 1'b0;
`endif
      end
      SEND: begin
        if (bus.tx_ready) begin
          state_n   = WAIT_RSP;
          rsp_idx_n = 2'd0;
          tmo_cnt_n = '0;
        end
      end
      WAIT_RSP: begin
        if (bus.rx_error) begin
          step_fail = 1'b1;
        end else if (bus.rx_valid) begin
          if (!rx_ok) begin
            step_fail = 1'b1;
          end else begin
            tmo_cnt_n = '0;
            if (id_rsp) wheel_n = (bus.rx_data == 8'h03);
            if (!last_rsp) begin
              rsp_idx_n = rsp_idx + 2'd1;
            end else if (step == LAST_STEP) begin
              state_n = RUN;
            end else begin
              step_n  = step + 4'd1;
              state_n = SEND;
            end
          end
        end else if (tmo_hit) begin
          step_fail = 1'b1;
        end else begin
          tmo_cnt_n = tmo_cnt + TW'(1);
        end
        if (step_fail) begin
          if (retry_cnt < RETRY_MAX) begin
            retry_n = retry_cnt + 2'd1;
            state_n = START;
          end else begin
            state_n = FAIL;
          end
        end
      end
      RUN: begin
`ifdef PS2MOUSE_INIT_HOTPLUG_EN
        // A fresh BAT (AA then 00) means the mouse was re-plugged or power-cycled.
        if (bus.rx_valid) begin
          if (hp_aa && (bus.rx_data == 8'h00)) begin
            state_n = START;
            wheel_n = 1'b0;
            retry_n = 2'd0;
            hp_aa_n = 1'b0;
          end else begin
            hp_aa_n = (bus.rx_data == 8'hAA);
          end
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= START;
      step      <= 4'd0;
      rsp_idx   <= 2'd0;
      tmo_cnt   <= '0;
      retry_cnt <= 2'd0;
      wheel     <= 1'b0;
`ifdef PS2MOUSE_INIT_HOTPLUG_EN
      hp_aa     <= 1'b0;
`endif
    end else if (clk_ena) begin
      state     <= state_n;
      step      <= step_n;
      rsp_idx   <= rsp_idx_n;
      tmo_cnt   <= tmo_cnt_n;
      retry_cnt <= retry_n;
      wheel     <= wheel_n;
`ifdef PS2MOUSE_INIT_HOTPLUG_EN
      hp_aa     <= hp_aa_n;
`endif
    end
  end

  assign bus.tx_valid = (state == SEND);
  assign bus.tx_data  = (state == SEND) ? cmd_byte : 8'h00;
  assign stream_en    = (state == RUN);
  assign init_done    = (state == RUN);
  assign init_fail    = (state == FAIL);
endmodule

// File: tb/tb_ps2mouse_init_seq.sv
// tb/tb_ps2mouse_init_seq.sv - self-checking bench for ps2mouse_init_seq with a behavioural mouse model
// Define PS2MOUSE_INIT_HOTPLUG_EN for both RTL and bench to cover hot-plug re-init.
module tb_ps2mouse_init_seq;
  localparam logic [7:0] SEQ [9] = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_ena;
  logic       stream_en, wheel, init_done, init_fail;
  logic [1:0] retry_cnt;

  ps2mouse_init_seq_if bus();

  ps2mouse_init_seq #(.C_ack_timeout(100), .C_bat_timeout(200), .C_retries(3)) dut (
    .clk(clk), .reset(reset), .clk_ena(clk_ena), .bus(bus),
    .stream_en(stream_en), .wheel(wheel), .init_done(init_done),
    .init_fail(init_fail), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, stab_err = 0;
  int fail_at, fail_kind, ena_div, rdy_hold, dmin, dmax;
  bit junk_en, silent;
  logic [7:0] id_byte;
  logic [7:0] txlog[$], exp_log[$], golden[$];
  logic [8:0] rxq[$];

  task automatic set_cfg();
    fail_at = -1; fail_kind = 0; id_byte = 8'h03; ena_div = 1; rdy_hold = -1;
    dmin = 0; dmax = 5; junk_en = 0; silent = 0;
  endtask

  // Mouse model: what a well-behaved mouse answers to each command, with an optional injected fault.
  function automatic void respond(input logic [7:0] b, input int idx);
    if (silent) return;
    if (idx == fail_at) begin
      case (fail_kind)
        0:       rxq.push_back({1'b0, 8'hFE});
        1:       rxq.push_back({1'b0, 8'hFC});
        2:       rxq.push_back({1'b1, 8'h00});
        default: rxq.push_back({1'b0, 8'h55});
      endcase
      return;
    end
    rxq.push_back({1'b0, 8'hFA});
    if (b == 8'hFF) begin rxq.push_back({1'b0, 8'hAA}); rxq.push_back({1'b0, 8'h00}); end
    if (b == 8'hF2) rxq.push_back({1'b0, id_byte});
  endfunction

  task automatic build_exp(input int fa);
    exp_log.delete();
    if (fa >= 0) for (int i = 0; i <= fa; i++) exp_log.push_back(SEQ[i]);
    for (int i = 0; i < 9; i++) exp_log.push_back(SEQ[i]);
  endtask

  function automatic int diff_q(input logic [7:0] a[$], input logic [7:0] b[$]);
    int d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) d++;
    return d;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; clk_ena = 1'b1; bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_error = 1'b0; bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    txlog.delete(); rxq.delete();
  endtask

  task automatic run_session(input int budget, output bit timed_out);
    int gap = 0, hold = 0, ntx = 0;
    bit pend = 0;
    logic [7:0] pend_data = 8'h00;
    timed_out = 1'b1;
    stab_err = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      cyc++;
      if (init_done || init_fail) begin
        bus.rx_valid = 1'b0; bus.rx_error = 1'b0; bus.tx_ready = 1'b0;
        timed_out = 1'b0;
        break;
      end
      if (pend && (bus.tx_valid !== 1'b1 || bus.tx_data !== pend_data)) stab_err++;
      clk_ena = (ena_div <= 1) || (cyc % ena_div == 0);
      hold = bus.tx_valid ? hold + 1 : 0;
      bus.tx_ready = (rdy_hold < 0) ? 1'($urandom_range(0, 1)) : (hold > rdy_hold);
      bus.rx_valid = 1'b0; bus.rx_error = 1'b0; bus.rx_data = 8'($urandom);
      if (clk_ena && rxq.size() > 0) begin
        if (gap == 0) begin
          {bus.rx_error, bus.rx_data} = rxq.pop_front();
          bus.rx_valid = ~bus.rx_error;
          gap = $urandom_range(dmin, dmax);
        end else gap--;
      end else if (junk_en && bus.tx_valid && !bus.tx_ready) begin
        bus.rx_valid = 1'($urandom_range(0, 1));
        bus.rx_error = ~bus.rx_valid;
      end
      pend = bus.tx_valid && !(bus.tx_ready && clk_ena);
      pend_data = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready && clk_ena) begin
        txlog.push_back(bus.tx_data);
        respond(bus.tx_data, ntx);
        ntx++;
        gap = $urandom_range(dmin, dmax);
      end
    end
  endtask

  task automatic idle(input int n, output int txv);
    txv = 0;
    clk_ena = 1'b1; bus.tx_ready = 1'b1; bus.rx_valid = 1'b0; bus.rx_error = 1'b0;
    repeat (n) begin @(negedge clk); if (bus.tx_valid) txv++; end
  endtask

  task automatic send_rx(input logic [7:0] b);
    clk_ena = 1'b1; bus.tx_ready = 1'b0; bus.rx_error = 1'b0; bus.rx_valid = 1'b1; bus.rx_data = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; clk_ena = 1'b0; bus.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%0b exp=0", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%0h exp=00", bus.tx_data); end
    checks++; if (stream_en !== 1'b0) begin errors++; $display("FAIL reset_stream_en got=%0b exp=0", stream_en); end
    checks++; if (wheel !== 1'b0) begin errors++; $display("FAIL reset_wheel got=%0b exp=0", wheel); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got=%0b exp=0", init_done); end
    checks++; if (init_fail !== 1'b0) begin errors++; $display("FAIL reset_init_fail got=%0b exp=0", init_fail); end
    checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL reset_retry_cnt got=%0d exp=0", retry_cnt); end
    reset = 1'b1; clk_ena = 1'b1; bus.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hFF) begin errors++; $display("FAIL first_ff_latency got=%0b/%0h exp=1/ff", bus.tx_valid, bus.tx_data); end
  endtask

  task automatic test_reset_mid_handshake();
    bit to; int n = 0;
    set_cfg(); do_reset();
    while (bus.tx_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL mid_wait_valid got=%0b exp=1", bus.tx_valid); end
    reset = 1'b0; clk_ena = 1'b0; bus.tx_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin errors++; $display("FAIL mid_reset_drop got=%0b/%0h exp=0/00", bus.tx_valid, bus.tx_data); end
    reset = 1'b1; clk_ena = 1'b1; bus.tx_ready = 1'b0; txlog.delete();
    run_session(20000, to); build_exp(-1);
    checks++; if (to || diff_q(txlog, exp_log) != 0 || init_done !== 1'b1) begin errors++; $display("FAIL mid_after_reset got=len%0d/done%0b exp=len9/done1", txlog.size(), init_done); end
  endtask

  task automatic test_normal();
    bit to; int txv;
    set_cfg(); do_reset(); run_session(20000, to); build_exp(-1);
    checks++; if (to) begin errors++; $display("FAIL normal_timeout got=expired exp=done"); end
    checks++; if (diff_q(txlog, exp_log) != 0) begin errors++; $display("FAIL normal_txlog got_len=%0d exp_len=%0d diffs=%0d", txlog.size(), exp_log.size(), diff_q(txlog, exp_log)); end
    checks++; if (init_done !== 1'b1 || stream_en !== 1'b1) begin errors++; $display("FAIL normal_done got=%0b/%0b exp=1/1", init_done, stream_en); end
    checks++; if (wheel !== 1'b1) begin errors++; $display("FAIL normal_wheel got=%0b exp=1", wheel); end
    checks++; if (retry_cnt !== 2'd0 || init_fail !== 1'b0) begin errors++; $display("FAIL normal_retry got=%0d/%0b exp=0/0", retry_cnt, init_fail); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL normal_tx_stable got=%0d exp=0", stab_err); end
    golden = txlog;
    idle(30, txv);
    checks++; if (txv != 0) begin errors++; $display("FAIL normal_run_no_tx got=%0d exp=0", txv); end
  endtask

  task automatic test_id_values();
    bit to;
    for (int k = 0; k < 4; k++) begin
      set_cfg(); id_byte = (k == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      do_reset(); run_session(20000, to);
      checks++; if (to || init_done !== 1'b1 || wheel !== (id_byte == 8'h03)) begin errors++; $display("FAIL id_%0h got=done%0b/wheel%0b exp=done1/wheel%0b", id_byte, init_done, wheel, id_byte == 8'h03); end
    end
  endtask

  task automatic test_nak_restart();
    bit to;
    set_cfg(); fail_at = 1; fail_kind = 0; do_reset(); run_session(20000, to); build_exp(1);
    checks++; if (diff_q(txlog, exp_log) != 0) begin errors++; $display("FAIL nak_txlog got_len=%0d exp_len=%0d", txlog.size(), exp_log.size()); end
    checks++; if (to || init_done !== 1'b1 || retry_cnt !== 2'd1) begin errors++; $display("FAIL nak_result got=done%0b/retry%0d exp=done1/retry1", init_done, retry_cnt); end
  endtask

  task automatic test_step_failures();
    bit to;
    for (int k = 0; k < 4; k++) begin
      set_cfg(); fail_at = $urandom_range(0, 8); fail_kind = $urandom_range(0, 3);
      do_reset(); run_session(20000, to); build_exp(fail_at);
      checks++; if (to || diff_q(txlog, exp_log) != 0 || init_done !== 1'b1 || retry_cnt !== 2'd1) begin errors++; $display("FAIL stepfail_%0d_%0d got=len%0d/retry%0d exp=len%0d/retry1", fail_at, fail_kind, txlog.size(), retry_cnt, exp_log.size()); end
    end
  endtask

  task automatic test_rx_in_send();
    bit to;
    set_cfg(); junk_en = 1; rdy_hold = 3; do_reset(); run_session(20000, to); build_exp(-1);
    checks++; if (to || diff_q(txlog, exp_log) != 0 || retry_cnt !== 2'd0 || init_done !== 1'b1) begin errors++; $display("FAIL rx_in_send got=len%0d/retry%0d exp=len9/retry0", txlog.size(), retry_cnt); end
  endtask

  task automatic test_silent();
    bit to; int txv;
    set_cfg(); silent = 1; do_reset(); run_session(20000, to);
    exp_log.delete(); repeat (4) exp_log.push_back(8'hFF);
    checks++; if (to) begin errors++; $display("FAIL silent_timeout got=expired exp=fail"); end
    checks++; if (diff_q(txlog, exp_log) != 0) begin errors++; $display("FAIL silent_txlog got_len=%0d exp_len=4", txlog.size()); end
    checks++; if (init_fail !== 1'b1 || retry_cnt !== 2'd3 || init_done !== 1'b0) begin errors++; $display("FAIL silent_result got=fail%0b/retry%0d/done%0b exp=1/3/0", init_fail, retry_cnt, init_done); end
    idle(300, txv);
    checks++; if (txv != 0 || init_fail !== 1'b1) begin errors++; $display("FAIL silent_hold got=tx%0d/fail%0b exp=0/1", txv, init_fail); end
  endtask

  task automatic test_clk_ena();
    bit to;
    set_cfg(); ena_div = 4; rdy_hold = 5; dmin = 40; dmax = 70;
    do_reset(); run_session(20000, to);
    checks++; if (to || diff_q(txlog, golden) != 0) begin errors++; $display("FAIL clkena_txlog got_len=%0d exp_len=%0d", txlog.size(), golden.size()); end
    checks++; if (init_done !== 1'b1 || retry_cnt !== 2'd0 || wheel !== 1'b1) begin errors++; $display("FAIL clkena_result got=done%0b/retry%0d/wheel%0b exp=1/0/1", init_done, retry_cnt, wheel); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL clkena_tx_stable got=%0d exp=0", stab_err); end
  endtask

  task automatic test_hotplug();
    bit to; int txv;
    set_cfg(); fail_at = 2; do_reset(); run_session(20000, to);
    checks++; if (to || init_done !== 1'b1 || retry_cnt !== 2'd1) begin errors++; $display("FAIL hp_setup got=done%0b/retry%0d exp=1/1", init_done, retry_cnt); end
    send_rx(8'hAA); send_rx(8'h08);
    idle(20, txv);
    checks++; if (txv != 0 || stream_en !== 1'b1) begin errors++; $display("FAIL hp_aa08 got=tx%0d/stream%0b exp=0/1", txv, stream_en); end
    send_rx(8'hAA); send_rx(8'h00);
`ifdef PS2MOUSE_INIT_HOTPLUG_EN
    checks++; if (stream_en !== 1'b0 || init_done !== 1'b0 || wheel !== 1'b0 || retry_cnt !== 2'd0) begin errors++; $display("FAIL hp_restart got=%0b/%0b/%0b/%0d exp=0/0/0/0", stream_en, init_done, wheel, retry_cnt); end
    set_cfg(); txlog.delete(); rxq.delete(); run_session(20000, to); build_exp(-1);
    checks++; if (to || diff_q(txlog, exp_log) != 0 || init_done !== 1'b1) begin errors++; $display("FAIL hp_reinit got=len%0d/done%0b exp=len9/done1", txlog.size(), init_done); end
`else
    idle(20, txv);
    checks++; if (txv != 0 || stream_en !== 1'b1 || retry_cnt !== 2'd1) begin errors++; $display("FAIL run_terminal got=tx%0d/stream%0b/retry%0d exp=0/1/1", txv, stream_en, retry_cnt); end
`endif
  endtask

  initial begin
    reset = 1'b0; clk_ena = 1'b0;
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_error = 1'b0; bus.rx_data = 8'h00;
    set_cfg();
    test_reset();
    test_reset_mid_handshake();
    test_normal();
    test_id_values();
    test_nak_restart();
    test_step_failures();
    test_rx_in_send();
    test_silent();
    test_clk_ena();
    test_hotplug();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=time_limit exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
